argmax_classifier: RTL and testbench

//  Output stage placed downstream of the final neuron layer. It captures the

---
 rtl/nn_pkg.sv | 23 ++
 rtl/argmax_classifier_if.sv | 44 ++++
 rtl/argmax_classifier.sv | 119 +++++++++++
 tb/tb_argmax_classifier.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network output stages.
//   activation_type : activation selector used by the neuron layers
//   argmax_state_t  : control states of the argmax classifier
//   INDEX_WIDTH(n)  : bits needed to index n classes, never less than one
package nn_pkg;

   typedef enum logic {
      RELU    = 1'b0,
      SIGMOID = 1'b1
   } activation_type;

   typedef enum logic [1:0] {
      WAITING  = 2'd0,
      SCANNING = 2'd1,
      DONE     = 2'd2
   } argmax_state_t;

   // A single class still needs a one-bit index port.
   function automatic int INDEX_WIDTH(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/argmax_classifier_if.sv
// Bundle between the final neuron layer and the argmax classifier.
//   input_ready  : one-cycle pulse, inputs valid this cycle (layer -> classifier)
//   inputs       : signed neuron outputs, one per class (layer -> classifier)
//   class_index  : index of the largest input (classifier -> consumer)
//   max_value    : value found at class_index (classifier -> consumer)
//   busy         : classifier is scanning or presenting a result
//   output_ready : one-cycle pulse, class_index/max_value valid
// master = the side producing neuron outputs and consuming the result,
// slave  = the classifier.
interface argmax_classifier_if
   import nn_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 10
);

   localparam int IW = INDEX_WIDTH(NUM_INPUTS);

   logic                         input_ready;
   logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS];
   logic [IW-1:0]                class_index;
   logic signed [DATA_WIDTH-1:0] max_value;
   logic                         busy;
   logic                         output_ready;

   modport master (
      output input_ready,
      output inputs,
      input  class_index,
      input  max_value,
      input  busy,
      input  output_ready
   );

   modport slave (
      input  input_ready,
      input  inputs,
      output class_index,
      output max_value,
      output busy,
      output output_ready
   );

endinterface

// File: rtl/argmax_classifier.sv
// Argmax output stage for the final neuron layer. Captures all neuron
// outputs on an input_ready pulse, then walks them one per cycle through a
// single signed comparator and reports the index/value of the largest with
// a one-cycle output_ready pulse. Strict '>' keeps the lowest index on ties.
// Ports:
//   clock : rising-edge system clock
//   reset : synchronous, active-high; aborts any scan in progress
//   bus   : argmax_classifier_if slave modport (see interface header)
module argmax_classifier
   import nn_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   argmax_classifier_if.slave   bus
);

   localparam int            IW         = INDEX_WIDTH(NUM_INPUTS);
   localparam logic [IW-1:0] LAST_INDEX = IW'(NUM_INPUTS - 1);
   localparam logic [IW-1:0] FIRST_SCAN = IW'(1);

   argmax_state_t state_reg, state_next;

   logic signed [DATA_WIDTH-1:0] captured_reg [NUM_INPUTS];
   logic signed [DATA_WIDTH-1:0] best_value_reg, best_value_next;
   logic [IW-1:0]                best_index_reg, best_index_next;
   logic [IW-1:0]                scan_index_reg, scan_index_next;
   logic [IW-1:0]                class_index_reg;
   logic signed [DATA_WIDTH-1:0] max_value_reg;

   logic accept;
   logic load_result;

   // Next-state and datapath control. The result registers are loaded from
   // the *next* best values so the final compare is already folded in on the
   // edge that enters DONE.
   always_comb begin
      state_next      = state_reg;
      best_value_next = best_value_reg;
      best_index_next = best_index_reg;
      scan_index_next = scan_index_reg;
      accept          = 1'b0;
      load_result     = 1'b0;

      case (state_reg)
         WAITING: begin
            if (bus.input_ready) begin
               accept          = 1'b1;
               best_value_next = bus.inputs[0];
               best_index_next = '0;
               scan_index_next = FIRST_SCAN;
               if (NUM_INPUTS == 1) begin
                  state_next  = DONE;
                  load_result = 1'b1;
               end else begin
                  state_next = SCANNING;
               end
            end
         end

         SCANNING: begin
            if (captured_reg[scan_index_reg] > best_value_reg) begin
               best_value_next = captured_reg[scan_index_reg];
               best_index_next = scan_index_reg;
            end
            scan_index_next = scan_index_reg + 1'b1;
            if (scan_index_reg == LAST_INDEX) begin
               state_next  = DONE;
               load_result = 1'b1;
            end
         end

         DONE: begin
            state_next = WAITING;
         end

         default: begin
            state_next = WAITING;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= WAITING;
         best_value_reg  <= '0;
         best_index_reg  <= '0;
         scan_index_reg  <= '0;
         class_index_reg <= '0;
         max_value_reg   <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            captured_reg[i] <= '0;
         end
      end else begin
         state_reg      <= state_next;
         best_value_reg <= best_value_next;
         best_index_reg <= best_index_next;
         scan_index_reg <= scan_index_next;
         // Captured once per acceptance and frozen for the rest of the scan.
         if (accept) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
               captured_reg[i] <= bus.inputs[i];
            end
         end
         if (load_result) begin
            class_index_reg <= best_index_next;
            max_value_reg   <= best_value_next;
         end
      end
   end

   assign bus.class_index  = class_index_reg;
   assign bus.max_value    = max_value_reg;
   assign bus.busy         = (state_reg != WAITING);
   assign bus.output_ready = (state_reg == DONE);

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: an N=4 instance for the main
// scenarios and an N=1 instance for the degenerate single-class case.
module tb_argmax_classifier;
   import nn_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   argmax_classifier_if #(.DATA_WIDTH(32), .NUM_INPUTS(4)) bus4 ();
   argmax_classifier_if #(.DATA_WIDTH(32), .NUM_INPUTS(1)) bus1 ();

   argmax_classifier #(.DATA_WIDTH(32), .NUM_INPUTS(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   argmax_classifier #(.DATA_WIDTH(32), .NUM_INPUTS(1)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   typedef struct {
      int ei;
      int ev;
      int due;
   } exp_t;

   exp_t exp4 [$];
   exp_t exp1 [$];
   exp_t e4;
   exp_t e1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitors: compare every output_ready pulse against the scoreboard.
   always @(negedge clock) begin
      if (bus4.output_ready) begin
         if (exp4.size() == 0) begin
            check("n4 unexpected output_ready", 1, 0);
         end else begin
            e4 = exp4.pop_front();
            check("n4 class_index", longint'(bus4.class_index), e4.ei);
            check("n4 max_value", longint'($signed(bus4.max_value)), e4.ev);
            check("n4 latency", cyc, e4.due);
            $display("n4 result idx=%0d val=%0d cycle=%0d", bus4.class_index,
                     $signed(bus4.max_value), cyc);
         end
      end
      if (bus1.output_ready) begin
         if (exp1.size() == 0) begin
            check("n1 unexpected output_ready", 1, 0);
         end else begin
            e1 = exp1.pop_front();
            check("n1 class_index", longint'(bus1.class_index), e1.ei);
            check("n1 max_value", longint'($signed(bus1.max_value)), e1.ev);
            check("n1 latency", cyc, e1.due);
            $display("n1 result idx=%0d val=%0d cycle=%0d", bus1.class_index,
                     $signed(bus1.max_value), cyc);
         end
      end
   end

   // Hand-computed vectors: inputs {v0,v1,v2,v3} -> expected index/value.
   int tv [6][4] = '{
      '{5, -3, 9, 8},
      '{-7, -2, -9, -4},
      '{3, 9, 9, 0},
      '{0, 0, 0, 0},
      '{32'sh8000_0000, 32'sh8000_0000, -1, 32'sh7fff_ffff},
      '{-1, -2, -3, 32'sh8000_0000}
   };
   int te_idx [6] = '{2, 1, 1, 0, 3, 0};
   int te_val [6] = '{9, -2, 9, 0, 32'sh7fff_ffff, -1};

   // Pulse input_ready for one cycle; returns at the negedge after acceptance.
   task automatic issue4(input int v0, input int v1, input int v2, input int v3,
                         input bit expect_result, input int ei, input int ev);
      @(negedge clock);
      bus4.inputs[0] = v0;
      bus4.inputs[1] = v1;
      bus4.inputs[2] = v2;
      bus4.inputs[3] = v3;
      bus4.input_ready = 1'b1;
      if (expect_result) exp4.push_back('{ei, ev, cyc + 4});
      $display("n4 issue {%0d,%0d,%0d,%0d} cycle=%0d", v0, v1, v2, v3, cyc);
      @(negedge clock);
      bus4.input_ready = 1'b0;
   endtask

   // Counts busy cycles from the current negedge until busy drops (bounded).
   task automatic count_busy4(output int n);
      n = 0;
      for (int k = 0; k < 30; k++) begin
         if (!bus4.busy) break;
         n++;
         @(negedge clock);
      end
   endtask

   int n_busy;
   int n_first;

   initial begin
      bus4.input_ready = 1'b0;
      bus1.input_ready = 1'b0;
      for (int i = 0; i < 4; i++) bus4.inputs[i] = 0;
      bus1.inputs[0] = 0;

      repeat (3) @(negedge clock);
      // Reset state, still in reset.
      check("reset n4 class_index", longint'(bus4.class_index), 0);
      check("reset n4 max_value", longint'($signed(bus4.max_value)), 0);
      check("reset n4 busy", longint'(bus4.busy), 0);
      check("reset n4 output_ready", longint'(bus4.output_ready), 0);
      check("reset n1 busy", longint'(bus1.busy), 0);
      reset = 1'b0;

      // Directed vectors, including signed extremes.
      for (int t = 0; t < 6; t++) begin
         issue4(tv[t][0], tv[t][1], tv[t][2], tv[t][3], 1'b1, te_idx[t], te_val[t]);
         count_busy4(n_busy);
         check("n4 busy length", n_busy, 4);
         @(negedge clock);
      end

      // Second input_ready one cycle after the first is ignored; the later
      // input changes must not disturb the frozen capture.
      issue4(1, 7, 2, 3, 1'b1, 1, 7);
      n_first = bus4.busy ? 1 : 0;
      bus4.inputs[0] = 100;
      bus4.inputs[1] = 0;
      bus4.inputs[2] = 0;
      bus4.inputs[3] = 0;
      bus4.input_ready = 1'b1;
      @(negedge clock);
      bus4.input_ready = 1'b0;
      count_busy4(n_busy);
      check("n4 busy length ignored pulse", n_first + n_busy, 4);
      repeat (2) @(negedge clock);

      // Reset during the second scan cycle aborts with no pulse.
      issue4(50, 60, 70, 80, 1'b0, 0, 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("abort class_index", longint'(bus4.class_index), 0);
      check("abort max_value", longint'($signed(bus4.max_value)), 0);
      check("abort busy", longint'(bus4.busy), 0);
      check("abort output_ready", longint'(bus4.output_ready), 0);
      reset = 1'b0;
      repeat (6) @(negedge clock);
      issue4(1, 2, 3, 4, 1'b1, 3, 4);
      count_busy4(n_busy);
      check("n4 busy length after abort", n_busy, 4);

      // input_ready coinciding with reset is not accepted.
      @(negedge clock);
      reset = 1'b1;
      bus4.input_ready = 1'b1;
      bus4.inputs[0] = 11;
      @(negedge clock);
      reset = 1'b0;
      bus4.input_ready = 1'b0;
      check("ready during reset busy", longint'(bus4.busy), 0);
      @(negedge clock);
      check("ready during reset busy later", longint'(bus4.busy), 0);

      // N=1: result one cycle after acceptance, back-to-back every 2 cycles.
      for (int t = 0; t < 4; t++) begin
         @(negedge clock);
         case (t)
            0:       bus1.inputs[0] = -5;
            1:       bus1.inputs[0] = 7;
            2:       bus1.inputs[0] = 32'sh7fff_ffff;
            default: bus1.inputs[0] = 32'sh8000_0000;
         endcase
         bus1.input_ready = 1'b1;
         exp1.push_back('{0, bus1.inputs[0], cyc + 1});
         $display("n1 issue {%0d} cycle=%0d", $signed(bus1.inputs[0]), cyc);
         @(negedge clock);
         bus1.input_ready = 1'b0;
         check("n1 busy after accept", longint'(bus1.busy), 1);
      end

      // Drain, then every expected result must have been seen.
      for (int k = 0; k < 20; k++) begin
         if (exp4.size() == 0 && exp1.size() == 0) break;
         @(negedge clock);
      end
      repeat (3) @(negedge clock);
      check("n4 missing results", exp4.size(), 0);
      check("n1 missing results", exp1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
